// File: rtl/cbus_ram_responder_pkg.sv
// rtl/cbus_ram_responder_pkg.sv - CBus request/response types, responder FSM states and burst-length decode
package cbus_ram_responder_pkg;

  typedef enum logic [2:0] {
    MSIZE1 = 3'd0,
    MSIZE2 = 3'd1,
    MSIZE4 = 3'd2,
    MSIZE8 = 3'd3
  } cbus_size_t;

  // Encoded as beats-1, so unlisted codes are legal on the wire but decode to one beat.
  typedef enum logic [3:0] {
    MLEN1  = 4'd0,
    MLEN2  = 4'd1,
    MLEN4  = 4'd3,
    MLEN8  = 4'd7,
    MLEN16 = 4'd15
  } cbus_len_t;

  typedef enum logic [1:0] {
    AXI_BURST_FIXED = 2'd0,
    AXI_BURST_INCR  = 2'd1,
    AXI_BURST_WRAP  = 2'd2
  } axi_burst_type_t;

  typedef struct packed {
    logic            valid;
    logic            is_write;
    cbus_size_t      size;
    logic [63:0]     addr;
    logic [7:0]      strobe;
    logic [63:0]     data;
    cbus_len_t       len;
    axi_burst_type_t burst;
  } cbus_req_t;

  typedef struct packed {
    logic        ready;
    logic        last;
    logic [63:0] data;
  } cbus_resp_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    BURST = 2'd2,
    GAP   = 2'd3
  } cbus_resp_state_t;

  function automatic logic [4:0] len_to_beats(cbus_len_t len);
    logic [4:0] beats;
    case (len)
      MLEN2:   beats = 5'd2;
      MLEN4:   beats = 5'd4;
      MLEN8:   beats = 5'd8;
      MLEN16:  beats = 5'd16;
      default: beats = 5'd1;
    endcase
    return beats;
  endfunction

endpackage

// File: rtl/cbus_ram_responder_if.sv
// rtl/cbus_ram_responder_if.sv - CBus request/response bundle with initiator and target views
interface cbus_ram_responder_if
  import cbus_ram_responder_pkg::*;
  ;
  cbus_req_t  creq;
  cbus_resp_t cresp;

  modport master (output creq, input cresp);
  modport slave  (input creq, output cresp);
endinterface

// File: rtl/cbus_ram_responder_bram.sv
// rtl/cbus_ram_responder_bram.sv - DEPTH x 64 RAM, combinational read, byte-strobed synchronous write
module cbus_ram_responder_bram #(
  parameter int DEPTH = 4096
) (
  input  logic                     i_clk,
  input  logic                     i_we,
  input  logic [7:0]               i_strobe,
  input  logic [$clog2(DEPTH)-1:0] i_addr,
  input  logic [63:0]              i_wdata,
  output logic [63:0]              o_rdata
);

  logic [63:0] r_mem [DEPTH];

  assign o_rdata = r_mem[i_addr];

  // Byte-lane write; contents are deliberately never reset.
  always_ff @(posedge i_clk) begin
    if (i_we) begin
      for (int i = 0; i < 8; i++) begin
        if (i_strobe[i]) begin
          r_mem[i_addr][8*i +: 8] <= i_wdata[8*i +: 8];
        end
      end
    end
  end

endmodule

// File: rtl/cbus_ram_responder.sv
// rtl/cbus_ram_responder.sv - CBus target serving bursts from on-chip RAM; CBUS_RESP_WAIT_EN adds first-beat wait states
module cbus_ram_responder
  import cbus_ram_responder_pkg::*;
#(
  parameter int DEPTH       = 4096,
  parameter int WAIT_CYCLES = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  cbus_ram_responder_if.slave   bus
);

  localparam int IW = $clog2(DEPTH);

  cbus_resp_state_t r_state;
  cbus_resp_state_t w_state_next;
  logic [IW-1:0]    r_idx_base;
  cbus_len_t        r_len;
  axi_burst_type_t  r_burst;
  logic             r_is_write;
  logic [4:0]       r_beat;
`ifdef CBUS_RESP_WAIT_EN
  logic [31:0]      r_wait;
`else
  logic             w_unused_wait;
  assign w_unused_wait = (WAIT_CYCLES != 0);
`endif

  logic [4:0]    w_last_beat;
  logic [IW-1:0] w_beat_ofs;
  logic [IW-1:0] w_idx;
  logic          w_beat_live;
  logic          w_is_last;
  logic          w_we;
  logic [63:0]   w_rdata;
  logic          w_unused_req;

  // Size and the address bits outside the word index carry no meaning here.
  assign w_unused_req = ^{bus.creq.size, bus.creq.addr};

  assign w_last_beat = len_to_beats(r_len) - 5'd1;
  assign w_beat_ofs  = (r_burst == AXI_BURST_FIXED) ? '0 : IW'(r_beat);
  assign w_idx       = r_idx_base + w_beat_ofs;
  // A beat only happens while the initiator still holds valid; reset also kills the in-flight write.
  assign w_beat_live = (r_state == BURST) && bus.creq.valid && !reset;
  assign w_is_last   = (r_beat == w_last_beat);
  assign w_we        = w_beat_live && r_is_write;

  cbus_ram_responder_bram #(.DEPTH(DEPTH)) u_bram (
    .i_clk    (clk),
    .i_we     (w_we),
    .i_strobe (bus.creq.strobe),
    .i_addr   (w_idx),
    .i_wdata  (bus.creq.data),
    .o_rdata  (w_rdata)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_state_next;
  end

  // Next-state decode; valid low in WAIT/BURST aborts the request.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE: begin
        if (bus.creq.valid) begin
`ifdef CBUS_RESP_WAIT_EN
          w_state_next = (WAIT_CYCLES > 0) ? WAIT : BURST;
`else
          w_state_next = BURST;
`endif
        end
      end
      WAIT: begin
`ifdef CBUS_RESP_WAIT_EN
        if (!bus.creq.valid)  w_state_next = IDLE;
        else if (r_wait == 0) w_state_next = BURST;
`else
        w_state_next = IDLE;
`endif
      end
      BURST: begin
        if (!bus.creq.valid) w_state_next = IDLE;
        else if (w_is_last)  w_state_next = GAP;
      end
      GAP:     w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  // Response beat: read data straight from RAM, zero data on writes.
  always_comb begin
    bus.cresp = '0;
    if (w_beat_live) begin
      bus.cresp.ready = 1'b1;
      bus.cresp.last  = w_is_last;
      bus.cresp.data  = r_is_write ? 64'd0 : w_rdata;
    end
  end

  // Request latch, beat counter and wait counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_idx_base <= '0;
      r_len      <= MLEN1;
      r_burst    <= AXI_BURST_FIXED;
      r_is_write <= 1'b0;
      r_beat     <= '0;
`ifdef CBUS_RESP_WAIT_EN
      r_wait     <= '0;
`endif
    end else begin
      case (r_state)
        IDLE: begin
          if (bus.creq.valid) begin
            r_idx_base <= bus.creq.addr[3 +: IW];
            r_len      <= bus.creq.len;
            r_burst    <= bus.creq.burst;
            r_is_write <= bus.creq.is_write;
            r_beat     <= '0;
`ifdef CBUS_RESP_WAIT_EN
            r_wait     <= 32'(WAIT_CYCLES - 1);
`endif
          end
        end
`ifdef CBUS_RESP_WAIT_EN
        WAIT: begin
          if (r_wait != 0) r_wait <= r_wait - 32'd1;
        end
`endif
        BURST: begin
          if (bus.creq.valid && !w_is_last) r_beat <= r_beat + 5'd1;
        end
        default: ;
      endcase
    end
  end

endmodule
